// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO-to-stream output adapter.
// Holds the default data width, the output buffer depth and the occupancy type,
// plus a modulo-depth pointer increment used by the circular buffer.
package fifo_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int BUF_DEPTH     = 3;

  // Occupancy 0..3 fits in two bits.
  typedef logic [1:0] occ_t;

  // Advance a buffer pointer, wrapping at BUF_DEPTH (not at the 2-bit range).
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/stream_buf3.sv
// Purpose: 3-entry in-order circular buffer holding words captured from upstream.
// Latency: push visible at head one cycle after the push edge; head word is combinational from storage.
// Backpressure: pop is ignored when empty, push is ignored when full without a pop; flush empties at next edge.
// Ports: clk/rst (async active-high); flush clears contents; push/push_data write tail;
//        pop advances head; head_data is the oldest word; occ is the current entry count.
module stream_buf3
  import fifo_pkg::*;
#(
  parameter int width = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output occ_t             occ
);

  logic [width-1:0] mem_q [BUF_DEPTH];
  logic [width-1:0] mem_d [BUF_DEPTH];
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  occ_t             occ_q, occ_d;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    // Guards keep occupancy inside 0..BUF_DEPTH even if a caller misbehaves.
    pop_ok   = pop && (occ_q != '0);
    push_ok  = push && ((occ_q != occ_t'(BUF_DEPTH)) || pop_ok);

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({push_ok, pop_ok})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_stream_out.sv
// Purpose: drain a 1-cycle-latency sync FIFO into a valid/ready stream via a 3-entry buffer.
// Latency: fifo_read in cycle t gives m_valid in cycle t+2; one word per cycle sustained.
// Backpressure: reads are issued only while buffered + in-flight words < 3, so m_ready never reaches fifo_read.
// Ports: clk/rst (async active-high); fifo_data_out/fifo_empty/fifo_read talk to the upstream FIFO;
//        flush discards buffered and in-flight words; m_data/m_valid/m_ready form the output stream;
//        words_sent counts downstream transfers and wraps at 16 bits.
module fifo_stream_out
  import fifo_pkg::*;
#(
  parameter int width = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] fifo_data_out,
  input  logic             fifo_empty,
  output logic             fifo_read,
  input  logic             flush,
  output logic [width-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      words_sent
);

  logic        inflight_q, inflight_d;
  logic [15:0] words_sent_q, words_sent_d;
  occ_t        occ;
  logic        push;
  logic        pop;
  logic [2:0]  credits_used;

  always_comb begin
    // Every slot is reserved at read time, so an arriving word always has room.
    credits_used = {1'b0, occ} + {2'b00, inflight_q};
    fifo_read    = ~rst & ~fifo_empty & ~flush & (credits_used < 3'(BUF_DEPTH));
    // The word landing this cycle belongs to last cycle's read; flush drops it.
    push         = inflight_q & ~flush;
    m_valid      = (occ != '0);
    pop          = m_valid & m_ready & ~flush;
    inflight_d   = fifo_read;
    words_sent_d = words_sent_q + 16'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q   <= 1'b0;
      words_sent_q <= '0;
    end else begin
      inflight_q   <= inflight_d;
      words_sent_q <= words_sent_d;
    end
  end

  stream_buf3 #(
    .width(width)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (fifo_data_out),
    .pop       (pop),
    .head_data (m_data),
    .occ       (occ)
  );

  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_fifo_stream_out.sv
module tb_fifo_stream_out;

  logic        clk;
  logic        rst;
  logic [15:0] fifo_data_out;
  logic        fifo_empty;
  logic        fifo_read;
  logic        flush;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] words_sent;

  int checks   = 0;
  int failures = 0;

  // Reference model state: upstream FIFO contents, captured words, in-flight word.
  logic [15:0] up_q[$];
  logic [15:0] buf_q[$];
  logic        infl_v;
  logic [15:0] infl_w;
  logic [15:0] sent_m;
  int          nreads;
  int          xfers;

  fifo_stream_out #(.width(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_read     (fifo_read),
    .flush         (flush),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .words_sent    (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] w);
    up_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic model_clear();
    buf_q.delete();
    infl_v = 1'b0;
    sent_m = '0;
  endtask

  // One clock cycle: sample and check mid-cycle, then advance model and upstream at the edge.
  task automatic cycle();
    int   occ_m;
    logic exp_rd;
    logic exp_vld;
    #2;
    occ_m   = buf_q.size();
    exp_rd  = !rst && !fifo_empty && !flush && (occ_m + int'(infl_v) < 3);
    exp_vld = (occ_m != 0);
    chk("fifo_read", 32'(fifo_read), 32'(exp_rd));
    chk("m_valid", 32'(m_valid), 32'(exp_vld));
    if (exp_vld) chk("m_data", 32'(m_data), 32'(buf_q[0]));
    chk("words_sent", 32'(words_sent), 32'(sent_m));
    if (exp_rd) nreads++;
    @(posedge clk);
    if (flush || rst) begin
      buf_q.delete();
      infl_v = 1'b0;
    end else begin
      if (exp_vld && m_ready) begin
        void'(buf_q.pop_front());
        sent_m = sent_m + 16'd1;
        xfers++;
      end
      if (infl_v) buf_q.push_back(infl_w);
      infl_v = 1'b0;
    end
    if (exp_rd) begin
      infl_v = 1'b1;
      infl_w = up_q.pop_front();
    end
    #1;
    // Upstream read data is only meaningful after an accepted read; otherwise junk.
    fifo_data_out = exp_rd ? infl_w : 16'($urandom);
    fifo_empty    = (up_q.size() == 0);
  endtask

  initial begin
    int          k;
    logic [15:0] first_w;
    logic [15:0] next_w;

    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data_out = '0;
    nreads = 0; xfers = 0;
    model_clear();
    @(posedge clk); #1;
    // Words already waiting during reset must not be read.
    for (int i = 1; i <= 5; i++) load(16'(i));
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_words_sent", 32'(words_sent), 32'd0);
    chk("rst_fifo_read", 32'(fifo_read), 32'd0);
    cycle();

    // Five-word stream with m_ready held high.
    rst = 1'b0; m_ready = 1'b1;
    repeat (10) cycle();
    chk("five_sent", 32'(words_sent), 32'd5);

    // Eight words under backpressure: exactly three reads, head held stable.
    m_ready = 1'b0; nreads = 0;
    for (int i = 0; i < 8; i++) load(16'($urandom));
    first_w = up_q[0];
    repeat (10) cycle();
    chk("bp_reads", 32'(nreads), 32'd3);
    chk("bp_head", 32'(m_data), 32'(first_w));
    chk("bp_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    repeat (14) cycle();
    chk("bp_sent", 32'(words_sent), 32'd13);

    // Alternating ready.
    for (int i = 0; i < 10; i++) load(16'($urandom));
    for (int i = 0; i < 30; i++) begin
      m_ready = (i % 2 == 0);
      cycle();
    end
    m_ready = 1'b1;
    repeat (6) cycle();
    chk("toggle_sent", 32'(words_sent), 32'd23);

    // Flush while two words are buffered and one is in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(16'($urandom));
    k = 0;
    while (!(buf_q.size() == 2 && infl_v) && k < 20) begin cycle(); k++; end
    chk("flush_setup", 32'(k < 20), 32'd1);
    next_w = up_q[0];
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    chk("flush_m_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    k = 0;
    while (!m_valid && k < 10) begin cycle(); k++; end
    chk("flush_next_word", 32'(m_data), 32'(next_w));
    repeat (8) cycle();

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) load(16'($urandom));
      m_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 1'b0; m_ready = 1'b1;
    repeat (10) cycle();

    // Asynchronous reset while two words are buffered.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(16'($urandom));
    k = 0;
    while (buf_q.size() != 2 && k < 20) begin cycle(); k++; end
    chk("rst_setup", 32'(k < 20), 32'd1);
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_words_sent", 32'(words_sent), 32'd0);
    chk("arst_fifo_read", 32'(fifo_read), 32'd0);
    model_clear();
    cycle();
    rst = 1'b0; m_ready = 1'b1;
    repeat (15) cycle();

    // Counter wrap: 65537 transfers from zero leaves words_sent at 1.
    rst = 1'b1;
    #1;
    model_clear();
    cycle();
    rst = 1'b0; m_ready = 1'b1;
    xfers = 0; k = 0;
    while (xfers < 65537 && k < 70000) begin
      if (up_q.size() < 4) begin
        load(16'($urandom));
        load(16'($urandom));
      end
      cycle();
      k++;
    end
    chk("wrap_budget", 32'(xfers), 32'd65537);
    chk("wrap_count", 32'(words_sent), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
